list_fifo: RTL



---
 rtl/list_fifo.sv | 84 ++++++++
 1 files changed

// File: rtl/list_fifo.sv
// Elastic ring-buffer FIFO with a registered output stage.
// Holds up to 2**AW ring words plus one output word, with flush.
module list_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  input  logic          i_flush,
  output logic [AW+1:0] o_count
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_rc;
  logic          r_valid;
  logic [DW-1:0] r_data;

  logic w_empty;
  logic w_acc;
  logic w_ld;
  logic w_rd;
  logic w_byp;
  logic w_wr;

  // rc never exceeds DEPTH, so its MSB alone marks a full ring
  assign o_ready = !r_rc[AW];
  assign w_empty = (r_rc == '0);
  assign w_acc   = i_valid && o_ready;
  assign w_ld    = !r_valid || i_ready;
  assign w_rd    = w_ld && !w_empty;
  assign w_byp   = w_ld && w_empty && w_acc;
  assign w_wr    = w_acc && !w_byp
                   && !RESET && !i_flush;

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = {1'b0, r_rc}
                   + {{(AW+1){1'b0}}, r_valid};

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_rc     <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_ld) begin
        if (w_rd) begin
          r_data   <= r_mem[r_rd_ptr];
          r_valid  <= 1'b1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else if (w_byp) begin
          r_data   <= i_data;
          r_valid  <= 1'b1;
        end else begin
          r_data   <= '0;
          r_valid  <= 1'b0;
        end
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_rc <= r_rc + 1'b1;
        2'b01:   r_rc <= r_rc - 1'b1;
        default: r_rc <= r_rc;
      endcase
    end
  end

endmodule
